// File: rtl/id_exe_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_issue
// Brief    : ID-stage decode, operand forwarding, load-use stall detection,
//            branch resolution, and the ID/EX pipeline register that feeds
//            the EXE_STAGE ALU.
// Revision : 1.0 - initial release
// ============================================================================
module id_exe_issue #(
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] dinst,
  input  logic [31:0] dpc4,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [31:0] ealu,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] bpc,
  output logic [2:0]  ealuc,
  output logic        ealuimm,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic        eshift,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic [4:0]  ern,
  output logic        eillegal
);

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_BNE  = 6'h05;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_ANDI = 6'h0C;
  localparam logic [5:0] c_OP_ORI  = 6'h0D;
  localparam logic [5:0] c_OP_XORI = 6'h0E;
  localparam logic [5:0] c_OP_LUI  = 6'h0F;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2B;

  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SRA  = 6'h03;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;
  localparam logic [2:0] c_ALU_SLL = 3'b101;
  localparam logic [2:0] c_ALU_SRL = 3'b110;
  localparam logic [2:0] c_ALU_SRA = 3'b111;

  // Instruction fields
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_sa;
  logic [15:0] w_imm16;
  logic [31:0] w_sext, w_zext;

  assign w_op    = dinst[31:26];
  assign w_rs    = dinst[25:21];
  assign w_rt    = dinst[20:16];
  assign w_rd    = dinst[15:11];
  assign w_sa    = dinst[10:6];
  assign w_funct = dinst[5:0];
  assign w_imm16 = dinst[15:0];
  assign w_sext  = {{16{w_imm16[15]}}, w_imm16};
  assign w_zext  = {16'd0, w_imm16};

  // Decoded controls
  logic [2:0]  w_aluc;
  logic        w_aluimm, w_shift, w_wreg, w_m2reg, w_wmem;
  logic [4:0]  w_rn;
  logic [31:0] w_imm;
  logic        w_use_rs, w_use_rt, w_br, w_bne, w_illegal;

  // Forwarded operands and issue control
  logic [31:0] w_fa, w_fb;
  logic        w_stall, w_bubble;

  // Registered ID/EX state
  logic [2:0]  r_ealuc;
  logic        r_ealuimm, r_eshift, r_ewreg, r_em2reg, r_ewmem, r_eillegal;
  logic [31:0] r_ea, r_eb, r_eimm;
  logic [4:0]  r_ern;

  // Decode opcode/funct into ALU op, immediate form, write-back controls and
  // which source registers the instruction really reads.
  always_comb begin
    w_aluc    = c_ALU_ADD;
    w_aluimm  = 1'b0;
    w_shift   = 1'b0;
    w_wreg    = 1'b0;
    w_m2reg   = 1'b0;
    w_wmem    = 1'b0;
    w_rn      = 5'd0;
    w_imm     = 32'd0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_br      = 1'b0;
    w_bne     = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      c_OP_R: begin
        w_wreg   = 1'b1;
        w_rn     = w_rd;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        case (w_funct)
          c_FN_ADD: w_aluc = c_ALU_ADD;
          c_FN_SUB: w_aluc = c_ALU_SUB;
          c_FN_AND: w_aluc = c_ALU_AND;
          c_FN_OR:  w_aluc = c_ALU_OR;
          c_FN_XOR: w_aluc = c_ALU_XOR;
          c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
            w_aluc   = (w_funct == c_FN_SLL) ? c_ALU_SLL :
                       (w_funct == c_FN_SRL) ? c_ALU_SRL : c_ALU_SRA;
            w_shift  = 1'b1;
            w_use_rs = 1'b0;
            w_imm    = {27'd0, w_sa};
          end
          default: begin
            // A bubbled illegal op reads nothing, so it can never stall.
            w_illegal = 1'b1;
            w_use_rs  = !NOP_ON_ILLEGAL;
            w_use_rt  = !NOP_ON_ILLEGAL;
          end
        endcase
      end
      c_OP_ADDI, c_OP_LW: begin
        w_aluimm = 1'b1;
        w_wreg   = 1'b1;
        w_m2reg  = (w_op == c_OP_LW);
        w_rn     = w_rt;
        w_use_rs = 1'b1;
        w_imm    = w_sext;
      end
      c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
        w_aluc   = (w_op == c_OP_ANDI) ? c_ALU_AND :
                   (w_op == c_OP_ORI)  ? c_ALU_OR  : c_ALU_XOR;
        w_aluimm = 1'b1;
        w_wreg   = 1'b1;
        w_rn     = w_rt;
        w_use_rs = 1'b1;
        w_imm    = w_zext;
      end
      c_OP_LUI: begin
        w_aluimm = 1'b1;
        w_wreg   = 1'b1;
        w_rn     = w_rt;
        w_imm    = {w_imm16, 16'd0};
      end
      c_OP_SW: begin
        w_aluimm = 1'b1;
        w_wmem   = 1'b1;
        w_rn     = w_rt;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_imm    = w_sext;
      end
      c_OP_BEQ, c_OP_BNE: begin
        w_br     = 1'b1;
        w_bne    = (w_op == c_OP_BNE);
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      default: begin
        // Without bubbling, an unknown opcode is treated as R-type add.
        w_illegal = 1'b1;
        w_wreg    = !NOP_ON_ILLEGAL;
        w_rn      = NOP_ON_ILLEGAL ? 5'd0 : w_rd;
        w_use_rs  = !NOP_ON_ILLEGAL;
        w_use_rt  = !NOP_ON_ILLEGAL;
      end
    endcase
  end

  // Operand A forwarding: EX result, then MEM result/load data, then regfile.
  always_comb begin
    w_fa = qa;
    if (w_rs == 5'd0)
      w_fa = 32'd0;
    else if (r_ewreg && !r_em2reg && (r_ern != 5'd0) && (r_ern == w_rs))
      w_fa = ealu;
    else if (mwreg && (mrn != 5'd0) && (mrn == w_rs))
      w_fa = mm2reg ? mmo : malu;
  end

  // Operand B forwarding, same priority as operand A.
  always_comb begin
    w_fb = qb;
    if (w_rt == 5'd0)
      w_fb = 32'd0;
    else if (r_ewreg && !r_em2reg && (r_ern != 5'd0) && (r_ern == w_rt))
      w_fb = ealu;
    else if (mwreg && (mrn != 5'd0) && (mrn == w_rt))
      w_fb = mm2reg ? mmo : malu;
  end

  // Load in EX whose result this instruction needs cannot be forwarded yet.
  assign w_stall  = r_ewreg && r_em2reg && (r_ern != 5'd0) &&
                    ((w_use_rs && (r_ern == w_rs)) || (w_use_rt && (r_ern == w_rt)));
  assign w_bubble = w_stall || w_br || (w_illegal && NOP_ON_ILLEGAL);

  assign stall = w_stall;
  assign pcsrc = w_br && !w_stall && (w_bne ? (w_fa != w_fb) : (w_fa == w_fb));
  assign bpc   = dpc4 + {w_sext[29:0], 2'b00};

  // ID/EX pipeline register; reset and every bubble load all-zero fields.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_ealuc    <= 3'd0;
      r_ealuimm  <= 1'b0;
      r_ea       <= 32'd0;
      r_eb       <= 32'd0;
      r_eimm     <= 32'd0;
      r_eshift   <= 1'b0;
      r_ewreg    <= 1'b0;
      r_em2reg   <= 1'b0;
      r_ewmem    <= 1'b0;
      r_ern      <= 5'd0;
      r_eillegal <= 1'b0;
    end else begin
      r_eillegal <= w_illegal && NOP_ON_ILLEGAL && !w_stall;
      r_ealuc    <= w_bubble ? 3'd0  : w_aluc;
      r_ealuimm  <= w_bubble ? 1'b0  : w_aluimm;
      r_ea       <= w_bubble ? 32'd0 : w_fa;
      r_eb       <= w_bubble ? 32'd0 : w_fb;
      r_eimm     <= w_bubble ? 32'd0 : w_imm;
      r_eshift   <= w_bubble ? 1'b0  : w_shift;
      r_ewreg    <= w_bubble ? 1'b0  : w_wreg;
      r_em2reg   <= w_bubble ? 1'b0  : w_m2reg;
      r_ewmem    <= w_bubble ? 1'b0  : w_wmem;
      r_ern      <= w_bubble ? 5'd0  : w_rn;
    end
  end

  assign ealuc    = r_ealuc;
  assign ealuimm  = r_ealuimm;
  assign ea       = r_ea;
  assign eb       = r_eb;
  assign eimm     = r_eimm;
  assign eshift   = r_eshift;
  assign ewreg    = r_ewreg;
  assign em2reg   = r_em2reg;
  assign ewmem    = r_ewmem;
  assign ern      = r_ern;
  assign eillegal = r_eillegal;

endmodule
`default_nettype wire
